// File: rtl/dmem_router.sv
// Data-memory request router: decodes each core load/store to data RAM (port 0)
// or MMIO (port 1), holds it until accepted, and returns one response per request.

`ifndef REG_SIZE
`define REG_SIZE 31
`endif

module dmem_router #(
  parameter logic [`REG_SIZE:0] SEL_MASK = 32'hF000_0000,
  parameter logic [`REG_SIZE:0] SEL_BASE = 32'h1000_0000,
  parameter int unsigned        TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [`REG_SIZE:0] req_addr,
  input  logic [`REG_SIZE:0] req_wdata,
  input  logic              req_we,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [`REG_SIZE:0] rsp_rdata,
  output logic              rsp_err,
  output logic [`REG_SIZE:0] dn_addr,
  output logic [`REG_SIZE:0] dn_wdata,
  output logic              dn_we,
  output logic [3:0]        dn_wstrb,
  output logic              p0_valid,
  output logic              p1_valid,
  input  logic              p0_ready,
  input  logic              p1_ready,
  input  logic              p0_rsp_valid,
  input  logic              p1_rsp_valid,
  input  logic [`REG_SIZE:0] p0_rdata,
  input  logic [`REG_SIZE:0] p1_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  // Last tcnt value before the transaction is declared hung.
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t             state, state_next;
  logic               sel;
  logic [7:0]         tcnt;
  logic               sel_ready, sel_rsp;
  logic [`REG_SIZE:0] sel_rdata;
  logic               accept, done, tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    p0_valid   = 1'b0;
    p1_valid   = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    tmo        = 1'b0;
    sel_ready  = sel ? p1_ready     : p0_ready;
    sel_rsp    = sel ? p1_rsp_valid : p0_rsp_valid;
    sel_rdata  = sel ? p1_rdata     : p0_rdata;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        p0_valid = !sel;
        p1_valid = sel;
        if (sel_ready && sel_rsp) done = 1'b1;
        else if (sel_ready)       state_next = S_WAIT;
        if (!done && tcnt == TLAST) tmo = 1'b1;
      end
      S_WAIT: begin
        if (sel_rsp)               done = 1'b1;
        else if (tcnt == TLAST)    tmo  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // Completion takes priority over timeout; both return to IDLE.
    if (done || tmo) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_addr   <= '0;
      dn_wdata  <= '0;
      dn_we     <= 1'b0;
      dn_wstrb  <= '0;
      sel       <= 1'b0;
      tcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done || tmo;
      rsp_err   <= tmo;
      rsp_rdata <= (done && !dn_we) ? sel_rdata : '0;
      if (accept) begin
        dn_addr  <= req_addr;
        dn_wdata <= req_wdata;
        dn_we    <= req_we;
        dn_wstrb <= req_wstrb;
        sel      <= ((req_addr & SEL_MASK) == SEL_BASE);
        tcnt     <= '0;
      end else if (state != S_IDLE) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_router.sv
// Bench for dmem_router: directed scenarios plus randomized transactions checked
// against a cycle-count model of request/response timing.

module tb_dmem_router;

  localparam int          T    = 8;
  localparam logic [31:0] MASK = 32'hF000_0000;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dn_addr, dn_wdata;
  logic        dn_we;
  logic [3:0]  dn_wstrb;
  logic        p0_valid, p1_valid, p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rdata, p1_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_router #(.SEL_MASK(MASK), .SEL_BASE(BASE), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_we(dn_we), .dn_wstrb(dn_wstrb),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_rsp_valid(p0_rsp_valid), .p1_rsp_valid(p1_rsp_valid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata)
  );

  // Expected outcome from the timing rules: the selected target is ready from
  // cycle r on and responds in cycle k (k >= r); anything not done by cycle T errors.
  function automatic void model(input logic we, input logic [31:0] rdata, input int r, input int k,
                                output int at, output logic err, output logic [31:0] rd,
                                output int vcount);
    if (k <= T) begin
      at = k + 1; err = 1'b0; rd = we ? 32'h0 : rdata;
    end else begin
      at = T + 1; err = 1'b1; rd = 32'h0;
    end
    vcount = (r < T) ? r : T;
  endfunction

  // Drives one transaction starting mid-cycle (after a negedge, router idle) and
  // returns what was observed; ends at the negedge of the response cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int r, input int k,
                         input logic [31:0] rdata, input int stray, input bit junk,
                         output int at, output logic err, output logic [31:0] rd,
                         output int vcount, output int first_v, output int wrong,
                         output int dn_bad, output logic rdy0);
    logic s;
    logic own_v, oth_v;
    s = ((addr & MASK) == BASE);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wdata; req_wstrb = wstrb;
    p0_ready = 1'b0; p1_ready = 1'b0; p0_rsp_valid = 1'b0; p1_rsp_valid = 1'b0;
    at = 0; err = 1'bx; rd = 'x; vcount = 0; first_v = 0; wrong = 0; dn_bad = 0;
    #1 rdy0 = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom); req_wstrb = 4'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (s) begin
        p1_ready = (cyc >= r); p1_rsp_valid = (cyc == k);
        p1_rdata = (cyc == k) ? rdata : $urandom;
        p0_ready = junk ? 1'($urandom) : 1'b0;
        p0_rsp_valid = (cyc == stray) || (junk && 1'($urandom));
        p0_rdata = $urandom;
      end else begin
        p0_ready = (cyc >= r); p0_rsp_valid = (cyc == k);
        p0_rdata = (cyc == k) ? rdata : $urandom;
        p1_ready = junk ? 1'($urandom) : 1'b0;
        p1_rsp_valid = (cyc == stray) || (junk && 1'($urandom));
        p1_rdata = $urandom;
      end
      @(negedge clk);
      own_v = s ? p1_valid : p0_valid;
      oth_v = s ? p0_valid : p1_valid;
      if (own_v) begin
        vcount++;
        if (first_v == 0) first_v = cyc;
        if (dn_addr !== addr || dn_wdata !== wdata || dn_we !== we || dn_wstrb !== wstrb) dn_bad++;
      end
      if (oth_v) wrong++;
      if (rsp_valid) begin
        at = cyc; err = rsp_err; rd = rsp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_wstrb = '0;
    p0_ready = 1'b0; p1_ready = 1'b0; p0_rsp_valid = 1'b0; p1_rsp_valid = 1'b0;
    p0_rdata = '0; p1_rdata = '0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got valid=%b err=%b want 0 0", rsp_valid, rsp_err); end
    checks++; if (p0_valid !== 1'b0 || p1_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b%b want 00", p0_valid, p1_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if (dn_addr !== 32'h0 || dn_wdata !== 32'h0 || dn_we !== 1'b0 || dn_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_dn: got %h %h %b %h want zeros", dn_addr, dn_wdata, dn_we, dn_wstrb); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_port0_load;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 3, 32'hDEADBEEF, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL p0_load_ready: got %b want 1", rdy); end
    checks++; if (at !== 4) begin errors++; $display("FAIL p0_load_latency: got cycle %0d want 4", at); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL p0_load_rdata: got %h want deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL p0_load_err: got %b want 0", err); end
    checks++; if (vc !== 1 || fv !== 1) begin errors++; $display("FAIL p0_load_valid: got %0d cycles from %0d want 1 from 1", vc, fv); end
    checks++; if (wr !== 0) begin errors++; $display("FAIL p0_load_p1_valid: got %0d cycles want 0", wr); end
  endtask

  task automatic test_port1_store_backpressure;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    run_txn(32'h1000_0004, 1'b1, 32'h0000_0055, 4'b0001, 4, 5, 32'hA5A5A5A5, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (vc !== 4 || fv !== 1) begin errors++; $display("FAIL p1_store_valid: got %0d cycles from %0d want 4 from 1", vc, fv); end
    checks++; if (db !== 0) begin errors++; $display("FAIL p1_store_dn_stable: got %0d bad cycles want 0", db); end
    checks++; if (at !== 6) begin errors++; $display("FAIL p1_store_latency: got cycle %0d want 6", at); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL p1_store_rsp: got rdata=%h err=%b want 0 0", rd, err); end
    checks++; if (wr !== 0) begin errors++; $display("FAIL p1_store_p0_valid: got %0d cycles want 0", wr); end
  endtask

  task automatic test_back_to_back;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 1, 1, 32'h1234_5678, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (at !== 2) begin errors++; $display("FAIL b2b_first_latency: got cycle %0d want 2", at); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL b2b_first_rdata: got %h want 12345678", rd); end
    run_txn(32'h0000_0300, 1'b0, 32'h0, 4'hF, 1, 1, 32'h8765_4321, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_rsp_cycle: got %b want 1", rdy); end
    checks++; if (fv !== 1) begin errors++; $display("FAIL b2b_second_valid: got first cycle %0d want 1", fv); end
    checks++; if (at !== 2 || rd !== 32'h8765_4321) begin errors++; $display("FAIL b2b_second_rsp: got cycle %0d rdata %h want 2 87654321", at, rd); end
  endtask

  task automatic test_timeout;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    run_txn(32'h1000_0010, 1'b0, 32'h0, 4'hF, NEVER, NEVER, 32'hFFFF_FFFF, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (at !== T + 1) begin errors++; $display("FAIL timeout_latency: got cycle %0d want %0d", at, T + 1); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got err=%b rdata=%h want 1 0", err, rd); end
    checks++; if (vc !== T) begin errors++; $display("FAIL timeout_valid_cycles: got %0d want %0d", vc, T); end
    run_txn(32'h1000_0014, 1'b0, 32'h0, 4'hF, 1, T, 32'hCAFE_F00D, 0, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (at !== T + 1 || err !== 1'b0) begin errors++; $display("FAIL timeout_edge_completion: got cycle %0d err=%b want %0d 0", at, err, T + 1); end
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL timeout_edge_rdata: got %h want cafef00d", rd); end
  endtask

  task automatic test_stray_responses;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    int seen;
    run_txn(32'h1000_0020, 1'b0, 32'h0, 4'hF, 1, 6, 32'h0BAD_F00D, 3, 1'b0, at, err, rd, vc, fv, wr, db, rdy);
    checks++; if (at !== 7 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL stray_wait: got cycle %0d rdata %h want 7 0badf00d", at, rd); end
    seen = 0;
    p0_rsp_valid = 1'b1; p1_rsp_valid = 1'b1; p0_ready = 1'b1; p1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    p0_rsp_valid = 1'b0; p1_rsp_valid = 1'b0; p0_ready = 1'b0; p1_ready = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL stray_idle: got %0d rsp cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_txn;
    int seen;
    req_valid = 1'b1; req_addr = 32'h1000_0040; req_we = 1'b0; req_wdata = '0; req_wstrb = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    #1;
    checks++; if (p1_valid !== 1'b1) begin errors++; $display("FAIL rstmid_req_valid_before: got %b want 1", p1_valid); end
    rst_n = 1'b0; #1;
    checks++; if (p0_valid !== 1'b0 || p1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_async_drop: got %b%b want 00", p0_valid, p1_valid); end
    @(negedge clk); rst_n = 1'b1;
    req_valid = 1'b1; req_addr = 32'h1000_0044;
    @(posedge clk); #1 req_valid = 1'b0; p1_ready = 1'b1;
    @(posedge clk); #1 p1_ready = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (p0_valid !== 1'b0 || p1_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_wait: got p=%b%b rsp_valid=%b want 00 0", p0_valid, p1_valid, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", req_ready); end
    seen = 0;
    p1_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    p1_rsp_valid = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d rsp cycles want 0", seen); end
  endtask

  task automatic test_random;
    int at, vc, fv, wr, db; logic err, rdy; logic [31:0] rd;
    int e_at, e_vc; logic e_err; logic [31:0] e_rd;
    logic [31:0] addr, wdata, rdata; logic we; logic [3:0] wstrb;
    int r, k;
    for (int n = 0; n < 40; n++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[31:28] = 4'h1;
      wdata = $urandom; rdata = $urandom; we = 1'($urandom); wstrb = 4'($urandom);
      r = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 10));
      k = ($urandom_range(0, 4) == 0 || r == NEVER) ? NEVER : r + int'($urandom_range(0, 8));
      model(we, rdata, r, k, e_at, e_err, e_rd, e_vc);
      run_txn(addr, we, wdata, wstrb, r, k, rdata, 0, 1'b1, at, err, rd, vc, fv, wr, db, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b want 1", n, rdy); end
      checks++; if (at !== e_at) begin errors++; $display("FAIL rnd%0d_latency: got cycle %0d want %0d", n, at, e_at); end
      checks++; if (err !== e_err || rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rsp: got err=%b rdata=%h want %b %h", n, err, rd, e_err, e_rd); end
      checks++; if (vc !== e_vc || wr !== 0) begin errors++; $display("FAIL rnd%0d_valid: got own=%0d other=%0d want %0d 0", n, vc, wr, e_vc); end
      checks++; if (db !== 0) begin errors++; $display("FAIL rnd%0d_dn_stable: got %0d bad cycles want 0", n, db); end
    end
  endtask

  initial begin
    test_reset();
    test_port0_load();
    test_port1_store_backpressure();
    test_back_to_back();
    test_timeout();
    test_stray_responses();
    test_reset_mid_txn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
